// File: rtl/preamble_serializer.sv
// preamble_serializer: transmit side of the serial pattern-detection link.
// Accepts parallel words over a valid/ready handshake and shifts each one
// out MSB first, one bit per clock, prefixed by a fixed sync preamble. The
// frame is followed by a fixed number of idle gap cycles.
//
// Optional build macro: PRESER_PARITY_EN
//   When defined, one even-parity bit (XOR of the payload) is appended after
//   the payload LSB, and frame_done moves to that bit.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a word; in_ready high (outside reset)
//   S_PRE   | preamble bits on dout, cnt_q = preamble bits still to send
//   S_DATA  | payload bits on dout, cnt_q = payload bits still to send
//   S_PAR   | parity bit on dout (PRESER_PARITY_EN only)
//   S_GAP   | idle gap after a frame, cnt_q = gap cycles still to wait

module preamble_serializer #(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = 4'b1010,
    parameter int               GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              busy
);

    // One counter serves the preamble, payload and gap phases, so it must
    // hold the largest of the three lengths.
    localparam int CNT_MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int CNT_MAX    = (CNT_MAX_PD > GAP_CYCLES) ? CNT_MAX_PD : GAP_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_PRE_LOAD  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
`ifdef PRESER_PARITY_EN
        S_PAR  = 3'd3,
`endif
        S_GAP  = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              dout_q;
    logic              dout_valid_q;
    logic              frame_done_q;
`ifdef PRESER_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    logic pre_bit_d;
    logic cnt_is_zero;
`ifndef PRESER_PARITY_EN
    logic cnt_is_one;
    logic last_on_pre_exit;
`endif

    assign cnt_is_zero = (cnt_q == '0);
`ifndef PRESER_PARITY_EN
    assign cnt_is_one       = (cnt_q == CNT_ONE);
    // A one-bit payload finishes on the very bit that leaves the preamble.
    assign last_on_pre_exit = (DATA_W == 1);
`endif

`ifdef PRESER_PARITY_EN
    // Parity is taken from the word as it is captured, not from the shifter.
    assign par_d = ^in_data;
`endif

    // Next preamble bit: with k bits still to send, the next one is PREAMBLE[k-1].
    always_comb begin
        pre_bit_d = 1'b0;
        for (int i = 0; i < PRE_W - 1; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
                pre_bit_d = PREAMBLE[i];
            end
        end
    end

    // Frame sequencer with registered serial outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PRESER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    // in_ready is high here because resetn is high.
                    if (in_valid) begin
                        state_q      <= S_PRE;
                        shreg_q      <= in_data;
                        cnt_q        <= CNT_PRE_LOAD;
                        dout_q       <= PREAMBLE[PRE_W-1];
                        dout_valid_q <= 1'b1;
`ifdef PRESER_PARITY_EN
                        par_q        <= par_d;
`endif
                    end
                end

                S_PRE: begin
                    if (cnt_is_zero) begin
                        state_q <= S_DATA;
                        dout_q  <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= CNT_DATA_LOAD;
`ifndef PRESER_PARITY_EN
                        frame_done_q <= last_on_pre_exit;
`endif
                    end else begin
                        dout_q <= pre_bit_d;
                        cnt_q  <= cnt_q - CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (cnt_is_zero) begin
`ifdef PRESER_PARITY_EN
                        state_q      <= S_PAR;
                        dout_q       <= par_q;
                        frame_done_q <= 1'b1;
`else
                        state_q      <= S_GAP;
                        dout_q       <= 1'b0;
                        dout_valid_q <= 1'b0;
                        cnt_q        <= CNT_GAP_LOAD;
`endif
                    end else begin
                        dout_q  <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q - CNT_ONE;
`ifndef PRESER_PARITY_EN
                        frame_done_q <= cnt_is_one;
`endif
                    end
                end

`ifdef PRESER_PARITY_EN
                S_PAR: begin
                    state_q      <= S_GAP;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    cnt_q        <= CNT_GAP_LOAD;
                end
`endif

                S_GAP: begin
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    if (cnt_is_zero) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    // Unused encodings recover to IDLE silently.
                    state_q      <= S_IDLE;
                    cnt_q        <= '0;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE) & resetn;
    assign busy       = (state_q != S_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_preamble_serializer.sv
// Testbench for preamble_serializer: directed steps followed by a random
// phase, every cycle checked against a frame-level reference model that
// queues the expected outputs of each accepted word.
`timescale 1ns/1ps

module tb_preamble_serializer;

    localparam int DATA_W     = 8;
    localparam int PRE_W      = 4;
    localparam int GAP_CYCLES = 2;
    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1010;
`ifdef PRESER_PARITY_EN
    localparam int FLEN = PRE_W + DATA_W + 1;
`else
    localparam int FLEN = PRE_W + DATA_W;
`endif
    localparam int PERIOD = 1 + FLEN + GAP_CYCLES;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              dout;
    logic              dout_valid;
    logic              frame_done;
    logic              busy;

    always #5 clk = ~clk;

    preamble_serializer #(
        .DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(PREAMBLE), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .dout(dout), .dout_valid(dout_valid),
        .frame_done(frame_done), .busy(busy)
    );

    // Stand-in for the downstream 1010 detector: registered pulse after the
    // last four line bits read 1,0,1,0 (oldest first).
    logic [3:0] det_hist  = '0;
    logic       det_pulse = 1'b0;
    always @(posedge clk) begin
        det_hist  <= {det_hist[2:0], dout};
        det_pulse <= ({det_hist[2:0], dout} == 4'b1010);
    end

    typedef struct packed {
        logic d;
        logic v;
        logic fd;
    } exp_t;

    exp_t exp_q[$];
    logic bitlog[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   fd_cnt = 0;
    logic det_seen;
    logic obs_accept;
    logic obs_ready;

    // Expected per-cycle outputs of one frame plus its gap.
    function automatic void push_frame(input logic [DATA_W-1:0] w);
        exp_t e;
        logic [PRE_W-1:0] pre_v;
        pre_v = PREAMBLE;
        for (int i = 0; i < FLEN; i++) begin
            e.v  = 1'b1;
            e.fd = (i == FLEN - 1);
            if (i < PRE_W)               e.d = pre_v[PRE_W-1-i];
            else if (i < PRE_W + DATA_W) e.d = w[DATA_W-1-(i-PRE_W)];
            else                         e.d = ^w;
            exp_q.push_back(e);
        end
        for (int i = 0; i < GAP_CYCLES; i++) begin
            e = '0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive inputs, check this cycle's outputs against the
    // model, then advance the model across the rising edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic rn);
        exp_t e;
        logic idle;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        resetn   = rn;
        #1;
        idle = (exp_q.size() == 0);
        if (idle) e = '0;
        else      e = exp_q[0];
        chk("dout",       dout,       e.d);
        chk("dout_valid", dout_valid, e.v);
        chk("frame_done", frame_done, e.fd);
        chk("in_ready",   in_ready,   idle & rn);
        chk("busy",       busy,       !idle);
        det_seen   = det_pulse;
        obs_ready  = in_ready;
        obs_accept = v & in_ready;
        if (dout_valid === 1'b1) bitlog.push_back(dout);
        if (frame_done === 1'b1) fd_cnt++;
        @(posedge clk);
        if (!rn)       exp_q.delete();
        else if (idle) begin
            if (v) push_frame(d);
        end else       void'(exp_q.pop_front());
        cyc_n++;
    endtask

    initial begin
        int         acc_n;
        int         acc_c [2];
        int         rdy_low;
        int         det_n;
        int         det_k;
        logic       orv;
        logic       andv;
        logic [11:0] got;

        // Reset held for two cycles.
        @(posedge clk);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0);

        // Single word immediately after release.
        bitlog.delete();
        fd_cnt = 0;
        cyc(1'b1, 8'hA5, 1'b1);
        chk("a5_accept_first", obs_accept, 1'b1);
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'($urandom), 1'b1);
        chk_val("a5_len", bitlog.size(), FLEN);
        for (int i = 0; i < 12; i++) got[11-i] = bitlog[i];
        chk_val("a5_bits", {20'd0, got}, {20'd0, 4'b1010, 8'hA5});
        chk_val("a5_frame_done_cnt", fd_cnt, 1);

        // Back-to-back words with in_valid held high.
        bitlog.delete();
        acc_n = 0;
        rdy_low = 0;
        acc_c[0] = 0;
        acc_c[1] = 0;
        for (int k = 0; k < 3 * PERIOD && acc_n < 2; k++) begin
            cyc(1'b1, (acc_n == 0) ? 8'hFF : 8'h00, 1'b1);
            if (obs_accept) begin
                acc_c[acc_n] = cyc_n;
                acc_n++;
            end else if (acc_n == 1 && !obs_ready) begin
                rdy_low++;
            end
        end
        chk_val("b2b_accepts", acc_n, 2);
        chk_val("b2b_spacing", acc_c[1] - acc_c[0], PERIOD);
        chk_val("b2b_ready_low", rdy_low, PERIOD - 1);
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'($urandom), 1'b1);
        chk_val("b2b_len", bitlog.size(), 2 * FLEN);
        orv  = 1'b0;
        andv = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            andv = andv & bitlog[PRE_W + i];
            orv  = orv  | bitlog[FLEN + PRE_W + i];
        end
        chk("b2b_payload_ff", andv, 1'b1);
        chk("b2b_payload_00", orv, 1'b0);

        // Source stalls in IDLE; random data must be ignored.
        bitlog.delete();
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'($urandom), 1'b1);
        chk_val("stall_no_bits", bitlog.size(), 0);

        // Reset during the third payload bit of 8'h3C.
        bitlog.delete();
        fd_cnt = 0;
        cyc(1'b1, 8'h3C, 1'b1);
        for (int k = 1; k < PRE_W + 3; k++) cyc(1'b0, 8'($urandom), 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk_val("abort_bits", bitlog.size(), PRE_W + 3);
        chk_val("abort_frame_done", fd_cnt, 0);

        // Clean frame after the aborted one.
        bitlog.delete();
        fd_cnt = 0;
        cyc(1'b1, 8'h81, 1'b1);
        chk("r81_accept", obs_accept, 1'b1);
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'($urandom), 1'b1);
        chk_val("r81_len", bitlog.size(), FLEN);
        chk_val("r81_frame_done_cnt", fd_cnt, 1);

        // Loopback into the 1010 detector with an all-zero payload.
        det_n = 0;
        det_k = -1;
        for (int k = 0; k <= PERIOD; k++) begin
            cyc(k == 0, 8'h00, 1'b1);
            if (det_seen === 1'b1) begin
                det_n++;
                det_k = k;
            end
        end
        chk_val("loop_det_pulses", det_n, 1);
        chk_val("loop_det_cycle", det_k, PRE_W + 1);

`ifdef PRESER_PARITY_EN
        bitlog.delete();
        cyc(1'b1, 8'h07, 1'b1);
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'h00, 1'b1);
        chk_val("par07_len", bitlog.size(), 13);
        chk("par07_bit", bitlog[12], 1'b1);
        bitlog.delete();
        cyc(1'b1, 8'h03, 1'b1);
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'h00, 1'b1);
        chk_val("par03_len", bitlog.size(), 13);
        chk("par03_bit", bitlog[12], 1'b0);
`endif

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom % 3) != 0, 8'($urandom), ($urandom % 60) != 0);
        end
        for (int k = 0; k < PERIOD; k++) cyc(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preamble_serializer.md
Name: preamble_serializer

Overview:
- Transmit side of the serial pattern-detection link: takes parallel words over a valid/ready handshake and shifts them out one bit per clock.
- Each word is prefixed by a fixed sync preamble (default b1010) so the downstream 1010 sequence detector can find the frame start.
- Sits between a word-producing source and the single-bit serial line driving the detector.

Parameters:
- DATA_W, 8, payload bits per frame (>=1)
- PRE_W, 4, preamble length in bits (>=1)
- PREAMBLE, 4'b1010, preamble pattern, sent MSB first (width PRE_W)
- GAP_CYCLES, 2, idle cycles after each frame before the next word is accepted (>=1)

Ports:
- clk  input  1  clock; all logic on posedge
- resetn  input  1  reset, synchronous, active-low
- in_valid  input  1  source presents in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  payload word, MSB sent first
- dout  output  1  serial bit (registered)
- dout_valid  output  1  dout carries a frame bit this cycle (registered)
- frame_done  output  1  one-cycle pulse coincident with the last frame bit on dout
- busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, PRE, DATA, PAR (only with the optional feature), GAP. State is encoded in a register with a bit counter and a DATA_W shift register.
- Reset: when resetn is low at a posedge, state goes to IDLE, counters and shift register clear, and dout, dout_valid and frame_done become 0. in_ready = (state==IDLE) & resetn, so in_ready is 0 while resetn is low.
- Reset mid-frame aborts the frame with no further bits and no frame_done. The first accept is possible in the first cycle with resetn high.
- Handshake: a word is accepted at a posedge where in_valid & in_ready. in_data is captured into the shift register and the state goes IDLE->PRE.
  - in_valid while in_ready=0 is ignored, and in_data need not be held.
  - The source must hold in_valid until acceptance.
- Bit timing: all outputs are registered.
  - At the accept edge, dout <= PREAMBLE[PRE_W-1] and dout_valid <= 1, so the first bit is visible the cycle after the handshake.
  - Each later edge advances one bit: the remaining PRE_W-1 preamble bits MSB->LSB, then DATA_W payload bits MSB->LSB.
  - dout_valid stays 1 for exactly PRE_W+DATA_W consecutive cycles (+1 with the optional feature). No bubbles.
- frame_done = 1 in the same cycle the final frame bit is on dout; 0 otherwise.
- After the final bit the state goes to GAP for GAP_CYCLES cycles with dout=0 and dout_valid=0, then to IDLE.
- Throughput: the next accept is earliest in the first IDLE cycle. Frame period = 1 + PRE_W + DATA_W (+1) + GAP_CYCLES cycles, i.e. 15 with defaults.
- The payload is not escaped. Preamble aliasing inside data is the receiver's concern.
- dout is 0 whenever dout_valid is 0.
- busy = 0 only in IDLE. Illegal state encodings return to IDLE on the next edge.

Optional Feature:
- Macro: PRESER_PARITY_EN.
- Defined:
  - Adds state PAR after DATA: one extra bit equal to the even parity (XOR) of the captured payload word.
  - frame_done moves to the parity-bit cycle.
  - Frame length becomes PRE_W+DATA_W+1.
  - Parity is computed at capture and held until sent.
- Undefined: no PAR state and no parity logic; frame ends on the payload LSB.

Test Plan:
- Reset then single word: hold resetn=0 for 2 cycles (in_ready=0, dout=0, dout_valid=0), release, in_valid=1, in_data=8'hA5.
  - Accept in the first cycle after release.
  - dout over the next 12 cycles = 1,0,1,0, 1,0,1,0,0,1,0,1, with dout_valid=1 throughout.
  - frame_done high only on the 12th bit.
  - Then 2 cycles of dout_valid=0, in_ready=0; in_ready=1 on the 3rd.
- Back-to-back: in_valid held high with words 8'hFF then 8'h00.
  - Accepts exactly 15 cycles apart.
  - Second frame payload bits all 0.
  - in_ready low for 14 of every 15 cycles.
- Stall source: in_valid=0 for 5 cycles in IDLE -> dout_valid=0, busy=0, in_ready=1 throughout. No frame is emitted.
- Reset mid-frame: drive resetn=0 on the 3rd payload bit of word 8'h3C.
  - Next cycle dout_valid=0 and no frame_done.
  - After release, a new word 8'h81 produces a clean full frame.
- Loopback: connect dout to the existing 1010 detector, send 8'h00.
  - Detector pulses exactly once, the cycle after the 4th preamble bit.
- With PRESER_PARITY_EN defined: 8'h07 -> 13-bit frame ending in parity bit 1, frame_done on that bit. 8'h03 -> final bit 0.
